// File: rtl/demux14_pkg.sv
// Shared definitions for the 1x4 demux, its capture stage and their testbenches.
package demux14_pkg;
    typedef logic [1:0] sel_t;

    localparam int   NUM_CH = 4;
    localparam sel_t CH_A   = 2'd0;
    localparam sel_t CH_B   = 2'd1;
    localparam sel_t CH_C   = 2'd2;
    localparam sel_t CH_D   = 2'd3;
endpackage

// File: rtl/demux14_capture_if.sv
// Bit-stream input and per-channel word output handshakes of demux14_capture.
// The err signal exists only when DEMUX14_CAPTURE_CHECK_EN is defined.
interface demux14_capture_if
    import demux14_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             in_vld;
    logic             in_rdy;
    sel_t             s;
    logic             a, b, c, d;
    logic [WIDTH-1:0] word_a, word_b, word_c, word_d;
    logic             vld_a, vld_b, vld_c, vld_d;
    logic             rdy_a, rdy_b, rdy_c, rdy_d;
`ifdef DEMUX14_CAPTURE_CHECK_EN
    logic             err;
`endif

    modport slave (
        input  in_vld, s, a, b, c, d, rdy_a, rdy_b, rdy_c, rdy_d,
`ifdef DEMUX14_CAPTURE_CHECK_EN
        output err,
`endif
        output in_rdy, word_a, word_b, word_c, word_d, vld_a, vld_b, vld_c, vld_d
    );

    modport master (
        output in_vld, s, a, b, c, d, rdy_a, rdy_b, rdy_c, rdy_d,
`ifdef DEMUX14_CAPTURE_CHECK_EN
        input  err,
`endif
        input  in_rdy, word_a, word_b, word_c, word_d, vld_a, vld_b, vld_c, vld_d
    );
endinterface

// File: rtl/demux14_capture_lane.sv
// One capture lane: MSB-first deserialiser, bit counter and a one-deep word
// holding register with a valid/ready output.
module demux14_capture_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_vld,
    input  logic             bit_in,
    output logic [WIDTH-1:0] word,
    output logic             vld,
    input  logic             rdy,
    output logic             stall
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-2:0] sh;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh_next;
    logic             last;

    assign sh_next = {sh, bit_in};
    assign last    = (cnt == CW'(WIDTH - 1));
    // The final bit may only land when the holding register is free or being drained this edge.
    assign stall   = last && vld && !rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh   <= '0;
            cnt  <= '0;
            word <= '0;
            vld  <= 1'b0;
        end else begin
            if (vld && rdy)
                vld <= 1'b0;
            if (bit_vld) begin
                sh <= sh_next[WIDTH-2:0];
                if (last) begin
                    word <= sh_next;
                    vld  <= 1'b1;
                    cnt  <= '0;
                end else begin
                    cnt  <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/demux14_capture.sv
// Captures the four demux output lines into per-channel WIDTH-bit words.
// Define DEMUX14_CAPTURE_CHECK_EN to add the sticky err flag for stray non-selected lines.
module demux14_capture
    import demux14_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    demux14_capture_if.slave  bus
);
    logic [NUM_CH-1:0]            lines, rdys, vlds, stall, bit_vld;
    logic [NUM_CH-1:0][WIDTH-1:0] words;
    logic                         acc;

    assign lines = {bus.d, bus.c, bus.b, bus.a};
    assign rdys  = {bus.rdy_d, bus.rdy_c, bus.rdy_b, bus.rdy_a};

    // in_rdy follows only the addressed lane, so other lanes' stalls never block it.
    assign bus.in_rdy = !stall[bus.s];
    assign acc        = bus.in_vld && bus.in_rdy;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        assign bit_vld[k] = acc && (bus.s == sel_t'(k));

        demux14_capture_lane #(.WIDTH(WIDTH)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .bit_vld (bit_vld[k]),
            .bit_in  (lines[bus.s]),
            .word    (words[k]),
            .vld     (vlds[k]),
            .rdy     (rdys[k]),
            .stall   (stall[k])
        );
    end

    assign bus.word_a = words[CH_A];
    assign bus.word_b = words[CH_B];
    assign bus.word_c = words[CH_C];
    assign bus.word_d = words[CH_D];
    assign bus.vld_a  = vlds[CH_A];
    assign bus.vld_b  = vlds[CH_B];
    assign bus.vld_c  = vlds[CH_C];
    assign bus.vld_d  = vlds[CH_D];

`ifdef DEMUX14_CAPTURE_CHECK_EN
    logic [NUM_CH-1:0] stray;
    assign stray = lines & ~(NUM_CH'(1) << bus.s);

    always_ff @(posedge clk) begin
        if (rst)
            bus.err <= 1'b0;
        else if (acc && (stray != '0))
            bus.err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_demux14_capture.sv
// Directed plan plus randomized traffic against a queue-based reference model.
module tb_demux14_capture;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demux14_capture_if #(.WIDTH(W)) bus ();
    demux14_capture #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Reference model: bits received so far per lane, plus the held word.
    bit         part[4][$];
    logic [W-1:0] hw[4];
    logic       hv[4];
    logic       err_m;
    logic       last_rdy;

    logic [3:0][W-1:0] obs_word;
    logic [3:0]        obs_vld;
    assign obs_word = {bus.word_d, bus.word_c, bus.word_b, bus.word_a};
    assign obs_vld  = {bus.vld_d, bus.vld_c, bus.vld_b, bus.vld_a};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge: drive, check in_rdy, clock, update model, check outputs.
    task automatic step(input logic r, input logic v, input logic [1:0] sel,
                        input logic [3:0] ln, input logic [3:0] rd);
        logic er;
        logic [W-1:0] w;
        rst = r;
        bus.in_vld = v;
        bus.s = sel;
        {bus.d, bus.c, bus.b, bus.a} = ln;
        {bus.rdy_d, bus.rdy_c, bus.rdy_b, bus.rdy_a} = rd;
        #1;
        er = !((part[sel].size() == W - 1) && hv[sel] && !rd[sel]);
        chk("in_rdy", 32'(bus.in_rdy), 32'(er));
        last_rdy = bus.in_rdy;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 4; k++) begin
                part[k].delete();
                hw[k] = '0;
                hv[k] = 1'b0;
            end
            err_m = 1'b0;
        end else begin
            for (int k = 0; k < 4; k++)
                if (hv[k] && rd[k]) hv[k] = 1'b0;
            if (v && er) begin
                part[sel].push_back(ln[sel]);
                if ((ln & ~(4'b1 << sel)) != 4'b0) err_m = 1'b1;
                if (part[sel].size() == W) begin
                    w = '0;
                    foreach (part[sel][i]) w = {w[W-2:0], 1'b0} | W'(part[sel][i]);
                    hw[sel] = w;
                    hv[sel] = 1'b1;
                    part[sel].delete();
                end
            end
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("word%0d", k), 32'(obs_word[k]), 32'(hw[k]));
            chk($sformatf("vld%0d", k), 32'(obs_vld[k]), 32'(hv[k]));
        end
`ifdef DEMUX14_CAPTURE_CHECK_EN
        chk("err", 32'(bus.err), 32'(err_m));
`endif
    endtask

    task automatic beat(input logic [1:0] sel, input logic bv, input logic [3:0] rd);
        step(1'b0, 1'b1, sel, 4'(bv) << sel, rd);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 2'd0, 4'h0, 4'h0);
    endtask

    initial begin
        logic [3:0] pat_a, pat_b, pat_c, pat_d;
        for (int k = 0; k < 4; k++) begin
            hw[k] = '0;
            hv[k] = 1'b0;
        end
        err_m = 1'b0;
        bus.in_vld = 1'b0; bus.s = 2'd0;
        {bus.d, bus.c, bus.b, bus.a} = 4'h0;
        {bus.rdy_d, bus.rdy_c, bus.rdy_b, bus.rdy_a} = 4'h0;
        @(negedge clk);

        // Reset state
        do_reset();
        chk("rst_vld", 32'(obs_vld), 32'h0);
        chk("rst_word_a", 32'(bus.word_a), 32'h0);

        // Lane a: 1,0,1,1
        pat_a = 4'b1011;
        for (int i = 3; i >= 0; i--) beat(2'd0, pat_a[i], 4'b0001);
        chk("t1_word_a", 32'(bus.word_a), 32'hB);
        chk("t1_vld_a", 32'(bus.vld_a), 32'h1);
        chk("t1_others", 32'(obs_vld[3:1]), 32'h0);
        step(1'b0, 1'b0, 2'd0, 4'h0, 4'b0001);
        chk("t1_vld_a_once", 32'(bus.vld_a), 32'h0);

        // Interleaved b and c
        do_reset();
        pat_b = 4'b1100; pat_c = 4'b0110;
        for (int i = 3; i >= 0; i--) begin
            beat(2'd1, pat_b[i], 4'hF);
            if (i == 0) chk("t2_vld_b", 32'(bus.vld_b), 32'h1);
            beat(2'd2, pat_c[i], 4'hF);
        end
        chk("t2_word_b", 32'(bus.word_b), 32'hC);
        chk("t2_word_c", 32'(bus.word_c), 32'h6);
        chk("t2_vld_c", 32'(bus.vld_c), 32'h1);

        // Lane d stall
        do_reset();
        for (int i = 0; i < 4; i++) beat(2'd3, 1'b1, 4'h0);
        chk("t3_word_f", 32'(bus.word_d), 32'hF);
        pat_d = 4'b1010;
        for (int i = 3; i >= 1; i--) begin
            beat(2'd3, pat_d[i], 4'h0);
            chk("t3_rdy_hi", 32'(last_rdy), 32'h1);
        end
        beat(2'd3, 1'b0, 4'h0);
        chk("t3_stall", 32'(last_rdy), 32'h0);
        chk("t3_hold", 32'(bus.word_d), 32'hF);
        beat(2'd3, 1'b0, 4'b1000);
        chk("t3_accept", 32'(last_rdy), 32'h1);
        chk("t3_word_d", 32'(bus.word_d), 32'hA);
        chk("t3_vld_d", 32'(bus.vld_d), 32'h1);

        // Two back-to-back words on lane a
        do_reset();
        pat_a = 4'b0011; pat_b = 4'b1001;
        for (int i = 3; i >= 0; i--) beat(2'd0, pat_a[i], 4'hF);
        chk("t4_word1", 32'(bus.word_a), 32'h3);
        for (int i = 3; i >= 0; i--) beat(2'd0, pat_b[i], 4'hF);
        chk("t4_word2", 32'(bus.word_a), 32'h9);
        chk("t4_vld2", 32'(bus.vld_a), 32'h1);

        // Reset mid-word on lane b
        do_reset();
        beat(2'd1, 1'b1, 4'hF);
        beat(2'd1, 1'b1, 4'hF);
        do_reset();
        pat_b = 4'b0110;
        for (int i = 3; i >= 0; i--) beat(2'd1, pat_b[i], 4'hF);
        chk("t5_word_b", 32'(bus.word_b), 32'h6);

`ifdef DEMUX14_CAPTURE_CHECK_EN
        do_reset();
        step(1'b0, 1'b1, 2'd0, 4'b0101, 4'hF);
        chk("t6_err", 32'(bus.err), 32'h1);
        for (int i = 0; i < 3; i++) beat(2'd0, 1'b0, 4'hF);
        chk("t6_word_a", 32'(bus.word_a), 32'h8);
        chk("t6_sticky", 32'(bus.err), 32'h1);
        do_reset();
        chk("t6_clear", 32'(bus.err), 32'h0);
`endif

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] sel;
            logic [3:0] ln, rd;
            sel = 2'($urandom_range(0, 3));
            ln  = 4'($urandom_range(0, 1)) << sel;
            if ($urandom_range(0, 19) == 0) ln = ln | 4'($urandom);
            rd  = 4'($urandom) & 4'($urandom | $urandom);
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), sel, ln, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
